// File: rtl/controlador_exibicao_rgb_pkg.sv
// Shared types and constants for the RGB playback sequencer of the memory game.
// Holds the FSM state encoding, the blank colour and small helper functions.
package controlador_exibicao_rgb_pkg;

    typedef enum logic [2:0] {
        inicial = 3'd0,
        carrega = 3'd1,
        mostra  = 3'd2,
        apaga   = 3'd3,
        fim     = 3'd4
    } estado_t;

    localparam logic [3:0] COR_APAGADA = 4'b0000;

    // Counter must be able to hold the longer of the two phase lengths.
    function automatic int largura_contador(input int t_aceso, input int t_apagado);
        int maior;
        maior = (t_aceso > t_apagado) ? t_aceso : t_apagado;
        return $clog2(maior + 1);
    endfunction

    function automatic logic eh_one_hot(input logic [3:0] palavra);
        return (palavra != 4'b0000) && ((palavra & (palavra - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/controlador_exibicao_rgb_contador_tempo.sv
// Clearable saturating up-counter with a terminal-count flag against a
// selectable target; shared by the on-time and blank-gap phases.
module contador_tempo #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               limpar,
    input  logic               contar,
    input  logic [LARGURA-1:0] alvo,
    output logic               terminal
);

    logic [LARGURA-1:0] valor_reg;
    logic [LARGURA-1:0] valor_next;

    always_comb begin
        valor_next = valor_reg;
        if (limpar) begin
            valor_next = '0;
        end else if (contar && (valor_reg != '1)) begin
            // Saturate instead of wrapping so a missed terminal can never restart a phase.
            valor_next = valor_reg + LARGURA'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valor_reg <= '0;
        end else begin
            valor_reg <= valor_next;
        end
    end

    assign terminal = (valor_reg == alvo);

endmodule

// File: rtl/controlador_exibicao_rgb.sv
// Plays the stored colour sequence on the RGB LED: each entry is shown for
// T_ACESO cycles followed by T_APAGADO blank cycles, from address 0 to limite.
module controlador_exibicao_rgb
    import controlador_exibicao_rgb_pkg::*;
#(
    parameter int T_ACESO     = 1000,
    parameter int T_APAGADO   = 500,
    parameter int LARGURA_END = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   parar,
    input  logic [LARGURA_END-1:0] limite,
    input  logic [3:0]             dados_mem,
    output logic [LARGURA_END-1:0] endereco,
    output logic [3:0]             dados_led,
    output logic                   exibindo,
    output logic                   pronto,
    output logic                   erro_dado
);

    localparam int LARGURA_CNT = largura_contador(T_ACESO, T_APAGADO);
    localparam logic [LARGURA_CNT-1:0] ALVO_ACESO   = LARGURA_CNT'(T_ACESO - 1);
    localparam logic [LARGURA_CNT-1:0] ALVO_APAGADO = LARGURA_CNT'(T_APAGADO - 1);

    estado_t                state_reg,    state_next;
    logic [LARGURA_END-1:0] endereco_reg, endereco_next;
    logic [LARGURA_END-1:0] limite_reg,   limite_next;
    logic [3:0]             dados_led_reg, dados_led_next;
    logic                   pronto_reg,   pronto_next;
    logic                   erro_reg,     erro_next;

    logic                   cnt_limpar;
    logic                   cnt_contar;
    logic [LARGURA_CNT-1:0] cnt_alvo;
    logic                   cnt_terminal;

    contador_tempo #(
        .LARGURA (LARGURA_CNT)
    ) u_contador_tempo (
        .clock    (clock),
        .reset    (reset),
        .limpar   (cnt_limpar),
        .contar   (cnt_contar),
        .alvo     (cnt_alvo),
        .terminal (cnt_terminal)
    );

    always_comb begin
        state_next     = state_reg;
        endereco_next  = endereco_reg;
        limite_next    = limite_reg;
        dados_led_next = dados_led_reg;
        pronto_next    = 1'b0;
        erro_next      = erro_reg;
        cnt_limpar     = 1'b0;
        cnt_contar     = 1'b0;
        cnt_alvo       = ALVO_ACESO;

        case (state_reg)
            inicial: begin
                dados_led_next = COR_APAGADA;
                if (iniciar) begin
                    limite_next   = limite;
                    erro_next     = 1'b0;
                    endereco_next = '0;
                    state_next    = carrega;
                end
            end
            carrega: begin
                if (eh_one_hot(dados_mem)) begin
                    dados_led_next = dados_mem;
                end else begin
                    dados_led_next = COR_APAGADA;
                    erro_next      = 1'b1;
                end
                cnt_limpar = 1'b1;
                state_next = mostra;
            end
            mostra: begin
                cnt_alvo = ALVO_ACESO;
                if (cnt_terminal) begin
                    cnt_limpar     = 1'b1;
                    dados_led_next = COR_APAGADA;
                    state_next     = apaga;
                end else begin
                    cnt_contar = 1'b1;
                end
            end
            apaga: begin
                cnt_alvo = ALVO_APAGADO;
                if (cnt_terminal) begin
                    cnt_limpar = 1'b1;
                    // Compare before incrementing so an all-ones limit never wraps.
                    if (endereco_reg == limite_reg) begin
                        state_next = fim;
                    end else begin
                        endereco_next = endereco_reg + LARGURA_END'(1);
                        state_next    = carrega;
                    end
                end else begin
                    cnt_contar = 1'b1;
                end
            end
            fim: begin
                pronto_next    = 1'b1;
                dados_led_next = COR_APAGADA;
                state_next     = inicial;
            end
            default: begin
                dados_led_next = COR_APAGADA;
                state_next     = inicial;
            end
        endcase

        // Abort overrides everything, including the fim pulse and an error found this cycle.
        if (parar && (state_reg != inicial)) begin
            state_next     = inicial;
            dados_led_next = COR_APAGADA;
            pronto_next    = 1'b0;
            erro_next      = erro_reg;
            cnt_limpar     = 1'b1;
            cnt_contar     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= inicial;
            endereco_reg  <= '0;
            limite_reg    <= '0;
            dados_led_reg <= COR_APAGADA;
            pronto_reg    <= 1'b0;
            erro_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            endereco_reg  <= endereco_next;
            limite_reg    <= limite_next;
            dados_led_reg <= dados_led_next;
            pronto_reg    <= pronto_next;
            erro_reg      <= erro_next;
        end
    end

    assign endereco  = endereco_reg;
    assign dados_led = dados_led_reg;
    assign exibindo  = (state_reg != inicial);
    assign pronto    = pronto_reg;
    assign erro_dado = erro_reg;

endmodule

// File: tb/tb_controlador_exibicao_rgb.sv
// Scoreboard bench for the RGB playback sequencer: a timeline model pushes the
// expected per-cycle outputs of each playback, popped and compared every cycle.
module tb_controlador_exibicao_rgb;

    localparam int T_ACESO   = 3;
    localparam int T_APAGADO = 2;
    localparam int LE        = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniciar;
    logic          parar;
    logic [LE-1:0] limite;
    logic [3:0]    dados_mem;
    logic [LE-1:0] endereco;
    logic [3:0]    dados_led;
    logic          exibindo;
    logic          pronto;
    logic          erro_dado;

    logic [3:0] mem [0:(1<<LE)-1];

    typedef struct packed {
        logic [3:0]    led;
        logic          exib;
        logic          pr;
        logic          erro;
        logic [LE-1:0] ender;
    } amostra_t;

    amostra_t fila[$];
    amostra_t esp;
    amostra_t obs;
    int checks   = 0;
    int failures = 0;

    controlador_exibicao_rgb #(
        .T_ACESO     (T_ACESO),
        .T_APAGADO   (T_APAGADO),
        .LARGURA_END (LE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .parar     (parar),
        .limite    (limite),
        .dados_mem (dados_mem),
        .endereco  (endereco),
        .dados_led (dados_led),
        .exibindo  (exibindo),
        .pronto    (pronto),
        .erro_dado (erro_dado)
    );

    assign dados_mem = mem[endereco];

    always #5 clock = ~clock;

    function automatic amostra_t observar();
        return amostra_t'({dados_led, exibindo, pronto, erro_dado, endereco});
    endfunction

    function automatic logic cor_valida(input logic [3:0] w);
        return (w == 4'd1) || (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
    endfunction

    // Expected timeline from the carrega sample of entry 0 up to one idle cycle after pronto.
    task automatic push_run(input int lim);
        logic       e = 1'b0;
        logic [3:0] cor;
        for (int i = 0; i <= lim; i++) begin
            fila.push_back(amostra_t'({4'b0000, 1'b1, 1'b0, e, LE'(i)}));
            if (cor_valida(mem[i])) begin
                cor = mem[i];
            end else begin
                cor = 4'b0000;
                e   = 1'b1;
            end
            repeat (T_ACESO)   fila.push_back(amostra_t'({cor,     1'b1, 1'b0, e, LE'(i)}));
            repeat (T_APAGADO) fila.push_back(amostra_t'({4'b0000, 1'b1, 1'b0, e, LE'(i)}));
        end
        fila.push_back(amostra_t'({4'b0000, 1'b1, 1'b0, e, LE'(lim)}));
        fila.push_back(amostra_t'({4'b0000, 1'b0, 1'b1, e, LE'(lim)}));
        fila.push_back(amostra_t'({4'b0000, 1'b0, 1'b0, e, LE'(lim)}));
    endtask

    task automatic disparar(input int lim);
        iniciar = 1'b1;
        limite  = LE'(lim);
        push_run(lim);
        $display("run limite=%0d amostras=%0d", lim, fila.size());
    endtask

    task automatic carregar_basica();
        mem[0] = 4'b0001;
        mem[1] = 4'b0010;
        mem[2] = 4'b0100;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        iniciar = 1'b1;
        limite  = LE'(2);
        repeat (2) @(negedge clock);
        esp = amostra_t'(0);
        obs = observar();
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL reset_com_iniciar obtido=%h esperado=%h", obs, esp);
        end
        reset   = 1'b0;
        iniciar = 1'b0;
        @(negedge clock);
        obs = observar();
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL reset_ocioso obtido=%h esperado=%h", obs, esp);
        end
    endtask

    task automatic test_sequencia();
        carregar_basica();
        disparar(2);
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL sequencia n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
    endtask

    task automatic test_erro();
        carregar_basica();
        mem[1] = 4'b0011;
        disparar(2);
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL erro_dado n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
    endtask

    // Abort in the middle of the second entry's on-time, then restart from address 0.
    task automatic test_parar();
        carregar_basica();
        disparar(2);
        for (int n = 0; n <= 8; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL parar_antes n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
        parar = 1'b1;
        fila.delete();
        repeat (4) fila.push_back(amostra_t'({4'b0000, 1'b0, 1'b0, 1'b0, LE'(1)}));
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            parar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL parar_depois n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
        disparar(1);
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL parar_reinicio n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
    endtask

    // parar during the fim cycle must suppress the pronto pulse.
    task automatic test_parar_fim();
        carregar_basica();
        disparar(0);
        for (int n = 0; n <= 1 + T_ACESO + T_APAGADO; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL parar_fim_antes n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
        parar = 1'b1;
        fila.delete();
        repeat (3) fila.push_back(amostra_t'({4'b0000, 1'b0, 1'b0, 1'b0, LE'(0)}));
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            parar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL parar_fim_depois n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
    endtask

    task automatic test_iniciar_ignorado();
        carregar_basica();
        disparar(2);
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL iniciar_ignorado n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
            if (n == 5 || n == 9) begin
                iniciar = 1'b1;
                limite  = LE'(0);
            end
        end
        iniciar = 1'b0;
    endtask

    // Reset during the first blank gap returns every output to its reset value.
    task automatic test_reset_meio();
        carregar_basica();
        disparar(2);
        for (int n = 0; n <= T_ACESO + 1; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL reset_meio_antes n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
        reset = 1'b1;
        fila.delete();
        repeat (4) fila.push_back(amostra_t'(0));
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            reset = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL reset_meio_depois n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
    endtask

    task automatic test_limite_maximo();
        logic [3:0] um = 4'b0001;
        for (int i = 0; i < (1 << LE); i++) mem[i] = um << (i % 4);
        disparar((1 << LE) - 1);
        for (int n = 0; fila.size() > 0; n++) begin
            @(negedge clock);
            iniciar = 1'b0;
            esp = fila.pop_front();
            obs = observar();
            checks++;
            if (obs !== esp) begin
                failures++;
                $display("FAIL limite_maximo n=%0d obtido=%h esperado=%h", n, obs, esp);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        parar   = 1'b0;
        limite  = '0;
        for (int i = 0; i < (1 << LE); i++) mem[i] = 4'b0000;
        @(negedge clock);
        test_reset();
        test_sequencia();
        test_erro();
        test_parar();
        test_parar_fim();
        test_iniciar_ignorado();
        test_reset_meio();
        test_limite_maximo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
